// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter feeding the single write port of the fifo.
// Multi-beat packets keep the grant until their last beat. A one-entry output
// register sits between the winning requester and the fifo write side.
module fifo_wr_arbiter #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int SW = 2
) (
    input  logic           io_clk,
    input  logic           io_rst_n,
    input  logic [N-1:0]   io_req_valid,
    input  logic [N-1:0]   io_req_last,
    input  logic [N*W-1:0] io_req_bits,
    output logic [N-1:0]   io_req_ready,
    output logic           io_write_valid,
    output logic [W-1:0]   io_write_bits,
    output logic [SW-1:0]  io_write_src,
    input  logic           io_write_ready,
    output logic           io_busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_ptr_nxt;
    logic [SW-1:0] lock_id;
    logic [SW-1:0] lock_id_nxt;

    logic          can_load;
    logic          grant_found;
    logic [SW-1:0] grant_id;
    logic [SW:0]   scan_sum;
    logic [SW-1:0] scan_id;
    logic          sel_ok;
    logic [SW-1:0] sel_id;
    logic          sel_valid;
    logic          sel_last;
    logic [W-1:0]  sel_bits;
    logic          xfer;

    // Next requester index after id, wrapping at N-1 (N need not be a power of two).
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] id);
        if (id >= SW'(N - 1)) begin
            return '0;
        end
        return id + SW'(1);
    endfunction

    // Round-robin scan: first valid requester at or after rr_ptr, modulo N.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_sum    = '0;
        scan_id     = '0;
        for (int k = 0; k < N; k++) begin
            scan_sum = {1'b0, rr_ptr} + (SW + 1)'(k);
            if (scan_sum >= (SW + 1)'(N)) begin
                scan_sum = scan_sum - (SW + 1)'(N);
            end
            scan_id = scan_sum[SW-1:0];
            if (!grant_found && io_req_valid[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // Pick the serviced requester (lock owner or scan winner) and drive ready;
    // ready never looks at bits or last so upstream can't form a loop through it.
    always_comb begin
        can_load     = !io_write_valid || io_write_ready;
        sel_ok       = (state == LOCKED) || grant_found;
        sel_id       = (state == LOCKED) ? lock_id : grant_id;
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_bits     = '0;
        io_req_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_id == SW'(i)) begin
                sel_valid       = io_req_valid[i];
                sel_last        = io_req_last[i];
                sel_bits        = io_req_bits[i*W +: W];
                io_req_ready[i] = io_rst_n && sel_ok && can_load;
            end
        end
        xfer = io_rst_n && sel_ok && can_load && sel_valid;
    end

    // Next state: a last beat releases the lock and advances the pointer past
    // the sender; a non-last beat locks onto its sender.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        lock_id_nxt = lock_id;
        if (xfer) begin
            if (sel_last) begin
                state_nxt  = IDLE;
                rr_ptr_nxt = wrap_inc(sel_id);
            end else begin
                state_nxt   = LOCKED;
                lock_id_nxt = sel_id;
            end
        end
    end

    // Arbitration state register; reset abandons any lock and restarts at 0.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    // Output register: load on accept, clear valid on a drain without a load.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            io_write_valid <= 1'b0;
            io_write_bits  <= '0;
            io_write_src   <= '0;
        end else if (xfer) begin
            io_write_valid <= 1'b1;
            io_write_bits  <= sel_bits;
            io_write_src   <= sel_id;
        end else if (io_write_ready) begin
            io_write_valid <= 1'b0;
        end
    end

    assign io_busy = (state == LOCKED) || io_write_valid;

endmodule
